// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE program loader: FSM state encoding,
// stream byte/word widths and a state-class helper.
package simple_pkg;

   localparam int LOADER_BYTE_W = 8;
   localparam int LOADER_WORD_W = 16;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LEN_HI  = 4'd1,
      ST_LEN_LO  = 4'd2,
      ST_DATA_HI = 4'd3,
      ST_DATA_LO = 4'd4,
      ST_WRITE   = 4'd5,
      ST_CHK_HI  = 4'd6,
      ST_CHK_LO  = 4'd7,
      ST_DONE    = 4'd8,
      ST_ERR     = 4'd9
   } loader_state_e;

   // A load is in progress in every state except the three resting states.
   function automatic logic is_active(input loader_state_e s);
      return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
   endfunction

endpackage

// File: rtl/byte_pair_asm.sv
// Big-endian byte pair assembler: captures the high byte, then presents
// {high, current byte} together with a strobe on the low-byte accept.
// Shared by the length, data and checksum fields of the load stream.
module byte_pair_asm
   import simple_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     hi_en,
   input  logic                     lo_en,
   input  logic [LOADER_BYTE_W-1:0] byte_in,
   output logic [LOADER_WORD_W-1:0] word,
   output logic                     word_valid
);

   logic [LOADER_BYTE_W-1:0] hi_q;
   logic [LOADER_BYTE_W-1:0] hi_d;

   // Hold the high byte until its partner arrives.
   always_comb begin
      hi_d = hi_q;
      if (hi_en) begin
         hi_d = byte_in;
      end
   end

   // High-byte register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
      end else begin
         hi_q <= hi_d;
      end
   end

   // The word is complete in the same cycle the low byte is accepted, so
   // the FSM can act on it (length check, data capture) without a bubble.
   assign word       = {hi_q, byte_in};
   assign word_valid = lo_en;

endmodule

// File: rtl/prog_loader.sv
// Program loader for the SIMPLE processor: length-prefixed big-endian word
// stream into instruction/data RAM while the CPU is held.
// Optional trailing 16-bit checksum enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
   import simple_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        mem_wren,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Room left above BASE_ADDR, kept at 17 bits so N = 16'hFFFF cannot wrap.
   localparam logic [16:0] CAPACITY = 17'(MEM_WORDS) - {1'b0, BASE_ADDR};

   loader_state_e state_q, state_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   remain_q, remain_d;
   logic [15:0]   mem_addr_q, mem_addr_d;
   logic [15:0]   mem_data_q, mem_data_d;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]   acc_q, acc_d;
`endif

   logic        accept;
   logic        hi_en;
   logic        lo_en;
   logic [15:0] word;
   logic        word_valid;

   assign byte_ready = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
                                       ST_DATA_LO, ST_CHK_HI, ST_CHK_LO};
   assign accept     = byte_valid && byte_ready;
   assign hi_en      = accept && (state_q inside {ST_LEN_HI, ST_DATA_HI, ST_CHK_HI});
   assign lo_en      = accept && (state_q inside {ST_LEN_LO, ST_DATA_LO, ST_CHK_LO});

   byte_pair_asm u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .hi_en      (hi_en),
      .lo_en      (lo_en),
      .byte_in    (byte_in),
      .word       (word),
      .word_valid (word_valid)
   );

   // Next-state logic plus counter, write-port and accumulator updates.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
`ifdef LOADER_CHECKSUM_EN
      acc_d      = acc_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LEN_HI;
               addr_d  = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         ST_LEN_HI: begin
            if (accept) state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (word_valid) begin
               remain_d = word;
               if ({1'b0, word} > CAPACITY) begin
                  state_d = ST_ERR;
               end else if (word == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = ST_CHK_HI;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  state_d = ST_DATA_HI;
               end
            end
         end
         ST_DATA_HI: begin
            if (accept) state_d = ST_DATA_LO;
         end
         ST_DATA_LO: begin
            // Write port is loaded here so it is stable for the whole WRITE
            // cycle and holds until the next word's WRITE.
            if (word_valid) begin
               mem_addr_d = addr_q;
               mem_data_d = word;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            addr_d   = addr_q + 16'd1;
            remain_d = remain_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
            acc_d    = acc_q + mem_data_q;
`endif
            if (remain_q != 16'd1) begin
               state_d = ST_DATA_HI;
            end else begin
`ifdef LOADER_CHECKSUM_EN
               state_d = ST_CHK_HI;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK_HI: begin
            if (accept) state_d = ST_CHK_LO;
         end
         ST_CHK_LO: begin
            if (word_valid) state_d = (word == acc_q) ? ST_DONE : ST_ERR;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters and write-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= BASE_ADDR;
         remain_q   <= '0;
         mem_addr_q <= BASE_ADDR;
         mem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         acc_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
`ifdef LOADER_CHECKSUM_EN
         acc_q      <= acc_d;
`endif
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_wren = (state_q == ST_WRITE);
   assign busy     = is_active(state_q);
   assign cpu_hold = busy;
   assign done     = (state_q == ST_DONE);
   assign err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector tables for the basic
// image and the bad-checksum image, plus hand-written multi-cycle sequences.
module tb_prog_loader;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready, mem_wren, cpu_hold, busy, done, err;
   logic [15:0] mem_addr, mem_data;
   logic        byte_ready2, mem_wren2, cpu_hold2, busy2, done2, err2;
   logic [15:0] mem_addr2, mem_data2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   prog_loader #(.BASE_ADDR(16'h0000), .MEM_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_wren(mem_wren), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err)
   );

   prog_loader #(.BASE_ADDR(16'h00F0), .MEM_WORDS(256)) dut_hi (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready2), .mem_addr(mem_addr2),
      .mem_data(mem_data2), .mem_wren(mem_wren2), .cpu_hold(cpu_hold2),
      .busy(busy2), .done(done2), .err(err2)
   );

   // RAM write log for each instance, cleared by reset.
   logic [15:0] wr_a[$];
   logic [15:0] wr_d[$];
   int          hi_wr_cnt;
   int          ready_in_write;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_a.delete();
         wr_d.delete();
         hi_wr_cnt <= 0;
      end else begin
         if (mem_wren) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_data);
         end
         if (mem_wren2) hi_wr_cnt <= hi_wr_cnt + 1;
      end
   end

   initial ready_in_write = 0;
   always @(posedge clk) begin
      if ((mem_wren && byte_ready) || (mem_wren2 && byte_ready2))
         ready_in_write <= ready_in_write + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        st, bv;
      logic [7:0]  b;
      logic        rdy, wren;
      logic [15:0] addr, data;
      logic        bsy, dn, er;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic bv, input logic [7:0] b,
                      input logic rdy, input logic wren, input logic [15:0] addr,
                      input logic [15:0] data, input logic bsy, input logic dn,
                      input logic er);
      vec_t v;
      v.st = st; v.bv = bv; v.b = b; v.rdy = rdy; v.wren = wren;
      v.addr = addr; v.data = data; v.bsy = bsy; v.dn = dn; v.er = er;
      tbl.push_back(v);
   endtask

   // Per-cycle expectations for the 3-word image; outputs are those of the
   // state the loader is in while the row's inputs are presented.
   task automatic build_basic(input logic [7:0] chk_lo, input logic ok);
      tbl.delete();
      add(1, 0, 8'h00, 0, 0, 16'h0, 16'h0000, 0, 0, 0); // IDLE + start
      add(0, 1, 8'h00, 1, 0, 16'h0, 16'h0000, 1, 0, 0); // LEN_HI
      add(0, 1, 8'h03, 1, 0, 16'h0, 16'h0000, 1, 0, 0); // LEN_LO
      add(0, 1, 8'h12, 1, 0, 16'h0, 16'h0000, 1, 0, 0); // DATA_HI
      add(0, 1, 8'h34, 1, 0, 16'h0, 16'h0000, 1, 0, 0); // DATA_LO
      add(0, 1, 8'hAB, 0, 1, 16'h0, 16'h1234, 1, 0, 0); // WRITE (5 after start)
      add(0, 1, 8'hAB, 1, 0, 16'h0, 16'h1234, 1, 0, 0);
      add(0, 1, 8'hCD, 1, 0, 16'h0, 16'h1234, 1, 0, 0);
      add(0, 1, 8'h00, 0, 1, 16'h1, 16'hABCD, 1, 0, 0); // WRITE
      add(0, 1, 8'h00, 1, 0, 16'h1, 16'hABCD, 1, 0, 0);
      add(0, 1, 8'h01, 1, 0, 16'h1, 16'hABCD, 1, 0, 0);
      add(0, 1, 8'hBE, 0, 1, 16'h2, 16'h0001, 1, 0, 0); // last WRITE
`ifdef LOADER_CHECKSUM_EN
      add(0, 1, 8'hBE,  1, 0, 16'h2, 16'h0001, 1, 0, 0); // CHK_HI
      add(0, 1, chk_lo, 1, 0, 16'h2, 16'h0001, 1, 0, 0); // CHK_LO
      add(0, 0, 8'h00,  0, 0, 16'h2, 16'h0001, 0, ok, !ok);
`else
      add(0, 1, 8'hBE,  0, 0, 16'h2, 16'h0001, 0, ok, !ok); // DONE, not accepted
      add(0, 1, chk_lo, 0, 0, 16'h2, 16'h0001, 0, ok, !ok);
`endif
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         start = tbl[i].st; byte_valid = tbl[i].bv; byte_in = tbl[i].b;
         #1;
         chk($sformatf("%s[%0d].ready", tag, i), byte_ready, tbl[i].rdy);
         chk($sformatf("%s[%0d].wren", tag, i), mem_wren, tbl[i].wren);
         chk($sformatf("%s[%0d].addr", tag, i), mem_addr, tbl[i].addr);
         chk($sformatf("%s[%0d].data", tag, i), mem_data, tbl[i].data);
         chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].bsy);
         chk($sformatf("%s[%0d].hold", tag, i), cpu_hold, tbl[i].bsy);
         chk($sformatf("%s[%0d].done", tag, i), done, tbl[i].dn);
         chk($sformatf("%s[%0d].err", tag, i), err, tbl[i].er);
      end
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1; byte_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle_cyc();
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   // Offer one byte until the loader takes it; gaps randomly drop valid.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit acc = 1'b0;
      int n = 0;
      while (!acc && n < 60) begin
         @(negedge clk);
         byte_in = b;
         byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         acc = byte_valid && byte_ready;
         n++;
      end
      if (!acc) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_byte: byte %h accepted=0, required 1", b);
      end
   endtask

   task automatic send_basic(input logic [7:0] chk_lo, input bit gaps);
      logic [7:0] s [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
      for (int i = 0; i < 8; i++) send_byte(s[i], gaps);
      if (CHK_EN) begin
         send_byte(8'hBE, gaps);
         send_byte(chk_lo, gaps);
      end
   endtask

   task automatic check_log(input string tag);
      logic [15:0] ed [3] = '{16'h1234, 16'hABCD, 16'h0001};
      chk({tag, ".nwrites"}, wr_a.size(), 3);
      if (wr_a.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.waddr%0d", tag, i), wr_a[i], i);
            chk($sformatf("%s.wdata%0d", tag, i), wr_d[i], ed[i]);
         end
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".ready"}, byte_ready, 0);
      chk({tag, ".wren"}, mem_wren, 0);
      chk({tag, ".hold"}, cpu_hold, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".err"}, err, 0);
      chk({tag, ".addr"}, mem_addr, 16'h0000);
      chk({tag, ".data"}, mem_data, 16'h0000);
      chk({tag, ".addr_hi"}, mem_addr2, 16'h00F0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;

      // Basic image, continuous stream.
      build_basic(8'hBE ^ 8'hBC, 1'b1);
      run_table("basic");
      check_log("basic");

      // Same image with a bad checksum.
      do_reset();
      build_basic(8'h03, !CHK_EN);
      run_table("badsum");
      check_log("badsum");

      // Empty image.
      do_reset();
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      if (CHK_EN) begin
         send_byte(8'h00, 0); send_byte(8'h00, 0);
      end
      repeat (2) idle_cyc();
      #1;
      chk("empty.done", done, 1);
      chk("empty.err", err, 0);
      chk("empty.nwrites", wr_a.size(), 0);

      // Overflow at BASE 0xF0: 17 words do not fit, 16 do.
      do_reset();
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h11, 0);
      idle_cyc();
      #1;
      chk("ovf17.err", err2, 1);
      chk("ovf17.busy", busy2, 0);
      chk("ovf17.nwrites", hi_wr_cnt, 0);
      chk("ovf17.base0_busy", busy, 1);
      do_reset();
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h10, 0);
      idle_cyc();
      #1;
      chk("fit16.err", err2, 0);
      chk("fit16.ready", byte_ready2, 1);

      // Full-size and oversize lengths at BASE 0.
      do_reset();
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      idle_cyc();
      #1;
      chk("fit256.err", err, 0);
      chk("fit256.busy", busy, 1);
      do_reset();
      pulse_start();
      send_byte(8'hFF, 0); send_byte(8'hFF, 0);
      idle_cyc();
      #1;
      chk("ffff.err", err, 1);
      chk("ffff.hold", cpu_hold, 0);
      chk("ffff.nwrites", wr_a.size(), 0);

      // Restart from ERR without reset.
      pulse_start();
      #1;
      chk("restart.err_cleared", err, 0);
      send_basic(8'h02, 0);
      repeat (3) idle_cyc();
      #1;
      chk("restart.done", done, 1);
      chk("restart.err", err, 0);
      check_log("restart");

      // Random gaps in byte_valid.
      do_reset();
      pulse_start();
      send_basic(8'h02, 1);
      repeat (3) idle_cyc();
      #1;
      chk("gaps.done", done, 1);
      chk("gaps.hold", cpu_hold, 0);
      check_log("gaps");

      // start while in DATA_HI is ignored.
      do_reset();
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h03, 0);
      @(negedge clk);
      start = 1'b1; byte_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("midstart.ready", byte_ready, 1);
      begin
         logic [7:0] s [6] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
         for (int i = 0; i < 6; i++) send_byte(s[i], 0);
      end
      if (CHK_EN) begin
         send_byte(8'hBE, 0); send_byte(8'h02, 0);
      end
      repeat (3) idle_cyc();
      #1;
      chk("midstart.done", done, 1);
      check_log("midstart");

      // Reset after the second write.
      do_reset();
      pulse_start();
      begin
         logic [7:0] s [6] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD};
         for (int i = 0; i < 6; i++) send_byte(s[i], 0);
      end
      idle_cyc();
      #1;
      chk("midrst.wren2", mem_wren, 1);
      chk("midrst.addr2", mem_addr, 16'h0001);
      idle_cyc();
      #1;
      chk("midrst.nwrites", wr_a.size(), 2);
      chk("midrst.data_hold", mem_data, 16'hABCD);
      chk("midrst.busy", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      @(negedge clk);
      rst_n = 1'b1;

      chk("ready_in_write", ready_in_write, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
